// File: rtl/byte_lane_packer.sv
// -----------------------------------------------------------------------------
// byte_lane_packer
//
// Collects 8-bit bytes tagged with a lane number and packs them into 16-bit
// words for a downstream byte-enabled register. A word is emitted when both
// lanes are filled, when a byte lands on an already-filled lane (collision),
// when a byte carries in_last, or, if enabled, after an idle timeout with a
// partial word held. Between emissions byteena is 2'b00, so the downstream
// register keeps its contents.
//
// Optional feature macro: BYTE_LANE_PACKER_TIMEOUT_EN
//   defined   -> idle counter and timeout flush are built
//   undefined -> no counter; partial words wait until completed, collided
//                or flushed by in_last; TIMEOUT is only range-checked
//
// Parameters
//   TIMEOUT   idle cycles with a partial word before a forced flush (1..255)
//
// Ports
//   clk       in   rising-edge clock
//   areset    in   asynchronous, active-high reset
//   in_valid  in   byte present on in_data
//   in_data   in   [7:0] byte value
//   in_lane   in   target lane: 0 = d[7:0], 1 = d[15:8]
//   in_last   in   flush the word after this byte
//   in_ready  out  registered; byte accepted when in_valid & in_ready
//   d         out  [15:0] packed word, holds its last emitted value
//   byteena   out  [1:0] lane enables, one-cycle pulse per emitted word
// -----------------------------------------------------------------------------
module byte_lane_packer #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_lane,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] d,
  output logic [1:0]  byteena
);

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("byte_lane_packer: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_PEND
  } state_e;

  // Registered state and outputs
  logic [15:0] hold_q,    hold_d;
  logic [1:0]  mask_q,    mask_d;
  logic        pend_q,    pend_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] d_q,       d_d;
  logic [1:0]  byteena_q, byteena_d;
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0]  cnt_q,     cnt_d;
`endif

  state_e      state;
  logic        accept;
  logic [1:0]  lane_bit;
  logic [15:0] byte_word;
  logic [15:0] held_word;

  // Expand a lane mask into a 16-bit bit mask.
  function automatic logic [15:0] lane_expand(input logic [1:0] m);
    return {{8{m[1]}}, {8{m[0]}}};
  endfunction

  // The state is fully described by pend and mask; decode it for readability.
  always_comb begin
    if (pend_q)               state = ST_PEND;
    else if (mask_q == 2'b00) state = ST_EMPTY;
    else                      state = ST_PARTIAL;
  end

  assign accept    = in_valid & in_ready_q;
  assign lane_bit  = in_lane ? 2'b10 : 2'b01;
  assign byte_word = in_lane ? {in_data, 8'h00} : {8'h00, in_data};
  // Un-enabled lanes are forced to zero on every emission.
  assign held_word = hold_q & lane_expand(mask_q);

  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    hold_d    = hold_q;
    mask_d    = mask_q;
    pend_d    = pend_q;
    d_d       = d_q;
    byteena_d = 2'b00;
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          if (in_last) begin
            // Lone byte with last: emit straight through, stay empty.
            d_d       = byte_word;
            byteena_d = lane_bit;
          end else begin
            hold_d = byte_word;
            mask_d = lane_bit;
          end
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end

      ST_PARTIAL: begin
        if (accept) begin
          if ((mask_q & lane_bit) == 2'b00) begin
            // Other lane: word complete; in_last adds nothing here.
            d_d       = held_word | byte_word;
            byteena_d = 2'b11;
            mask_d    = 2'b00;
          end else begin
            // Collision: flush the old byte, the new one starts a word. With
            // in_last it needs a second emission slot, taken via PEND.
            d_d       = held_word;
            byteena_d = mask_q;
            hold_d    = byte_word;
            mask_d    = lane_bit;
            pend_d    = in_last;
          end
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          d_d       = held_word;
          byteena_d = mask_q;
          mask_d    = 2'b00;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end

      ST_PEND: begin
        // in_ready is low here, so nothing can be accepted this cycle.
        d_d       = held_word;
        byteena_d = mask_q;
        mask_d    = 2'b00;
        pend_d    = 1'b0;
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      default: ;
    endcase

    in_ready_d = ~pend_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      hold_q     <= '0;
      mask_q     <= 2'b00;
      pend_q     <= 1'b0;
      in_ready_q <= 1'b1;
      d_q        <= '0;
      byteena_q  <= 2'b00;
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      hold_q     <= hold_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      in_ready_q <= in_ready_d;
      d_q        <= d_d;
      byteena_q  <= byteena_d;
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign d        = d_q;
  assign byteena  = byteena_q;

endmodule

// File: tb/tb_byte_lane_packer.sv
// -----------------------------------------------------------------------------
// tb_byte_lane_packer
//
// Directed checks of reset, full-word packing, collision with last, and the
// timeout behaviour for whichever BYTE_LANE_PACKER_TIMEOUT_EN setting the
// bench is built with, followed by a random stream compared against a
// behavioural model of the packer and of a downstream byte-enabled register.
// -----------------------------------------------------------------------------
module tb_byte_lane_packer;

  localparam int unsigned TIMEOUT = 8;

  logic        clk;
  logic        areset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_lane;
  logic        in_last;
  logic        in_ready;
  logic [15:0] d;
  logic [1:0]  byteena;

  int n_checks = 0;
  int n_errors = 0;

  byte_lane_packer #(.TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .areset   (areset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_lane  (in_lane),
    .in_last  (in_last),
    .in_ready (in_ready),
    .d        (d),
    .byteena  (byteena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 16-bit byte-enabled register driven by the packer.
  logic [15:0] q;
  always_ff @(posedge clk or posedge areset) begin
    if (areset) q <= '0;
    else begin
      if (byteena[0]) q[7:0]  <= d[7:0];
      if (byteena[1]) q[15:8] <= d[15:8];
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one edge; caller ensures in_ready is high.
  task automatic send(input logic [7:0] data, input logic lane, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_lane  = lane;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    #2;
    areset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model for the random phase
  // ---------------------------------------------------------------------------
  logic [7:0]  m_lo, m_hi;
  logic [1:0]  m_has;
  logic        m_pend;
  logic        m_rdy;
  logic [15:0] m_d;
  logic [1:0]  m_be;
  logic [15:0] m_q;
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
  int          m_cnt;
`endif

  task automatic m_reset();
    m_lo = '0; m_hi = '0; m_has = 2'b00; m_pend = 1'b0; m_rdy = 1'b1;
    m_d = '0; m_be = 2'b00; m_q = '0;
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
    m_cnt = 0;
`endif
  endtask

  task automatic m_emit_held();
    m_d  = {m_has[1] ? m_hi : 8'h00, m_has[0] ? m_lo : 8'h00};
    m_be = m_has;
  endtask

  task automatic m_store(input logic lane, input logic [7:0] data);
    if (lane) m_hi = data;
    else      m_lo = data;
    m_has[lane] = 1'b1;
  endtask

  // One clock edge with the current inputs; advances the model and compares.
  task automatic step(output logic acc);
    acc = in_valid && m_rdy;
    @(posedge clk);
    if (m_be[0]) m_q[7:0]  = m_d[7:0];
    if (m_be[1]) m_q[15:8] = m_d[15:8];
    m_be = 2'b00;
    if (m_pend) begin
      m_emit_held();
      m_has  = 2'b00;
      m_pend = 1'b0;
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
      m_cnt  = 0;
`endif
    end else if (acc) begin
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
      m_cnt = 0;
`endif
      if (m_has == 2'b00) begin
        if (in_last) begin
          m_d  = in_lane ? {in_data, 8'h00} : {8'h00, in_data};
          m_be = in_lane ? 2'b10 : 2'b01;
        end else begin
          m_store(in_lane, in_data);
        end
      end else if (m_has[in_lane]) begin
        m_emit_held();
        m_has = 2'b00;
        m_store(in_lane, in_data);
        m_pend = in_last;
      end else begin
        m_store(in_lane, in_data);
        m_emit_held();
        m_has = 2'b00;
      end
    end else if (m_has != 2'b00) begin
`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
      if (m_cnt == int'(TIMEOUT) - 1) begin
        m_emit_held();
        m_has = 2'b00;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
`endif
    end
    m_rdy = !m_pend;
    #1;
    check("rnd_d", d, m_d);
    check("rnd_byteena", {14'b0, byteena}, {14'b0, m_be});
    check("rnd_in_ready", {15'b0, in_ready}, {15'b0, m_rdy});
    check("rnd_q", q, m_q);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic acc;
    logic got;
    int   gap;

    areset   = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_lane  = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;

    check("reset_d", d, 16'h0000);
    check("reset_byteena", {14'b0, byteena}, 16'h0000);
    check("reset_in_ready", {15'b0, in_ready}, 16'h0001);

    // Reset discards a partial word, asynchronously.
    send(8'h12, 1'b0, 1'b0);
    check("partial_no_emit", {14'b0, byteena}, 16'h0000);
    #3;
    areset = 1'b1;
    #1;
    check("async_reset_d", d, 16'h0000);
    check("async_reset_byteena", {14'b0, byteena}, 16'h0000);
    check("async_reset_in_ready", {15'b0, in_ready}, 16'h0001);
    areset = 1'b0;
    send(8'h34, 1'b1, 1'b1);
    check("after_reset_d", d, 16'h3400);
    check("after_reset_byteena", {14'b0, byteena}, 16'h0002);
    tick();
    check("after_reset_idle_be", {14'b0, byteena}, 16'h0000);

    // Full word.
    send(8'hCD, 1'b0, 1'b0);
    check("full_first_be", {14'b0, byteena}, 16'h0000);
    send(8'hAB, 1'b1, 1'b0);
    check("full_d", d, 16'hABCD);
    check("full_byteena", {14'b0, byteena}, 16'h0003);
    tick();
    check("full_hold_d", d, 16'hABCD);
    check("full_idle_be", {14'b0, byteena}, 16'h0000);

    // Collision with last, then a byte offered while in_ready is low.
    send(8'h11, 1'b1, 1'b0);
    check("coll_first_be", {14'b0, byteena}, 16'h0000);
    send(8'h22, 1'b1, 1'b1);
    check("coll_old_d", d, 16'h1100);
    check("coll_old_be", {14'b0, byteena}, 16'h0002);
    check("coll_ready_low", {15'b0, in_ready}, 16'h0000);
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_lane  = 1'b0;
    in_last  = 1'b1;
    tick();
    check("pend_d", d, 16'h2200);
    check("pend_be", {14'b0, byteena}, 16'h0002);
    check("pend_ready_back", {15'b0, in_ready}, 16'h0001);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("post_pend_d", d, 16'h0077);
    check("post_pend_be", {14'b0, byteena}, 16'h0001);
    tick();
    check("post_pend_idle_be", {14'b0, byteena}, 16'h0000);

`ifdef BYTE_LANE_PACKER_TIMEOUT_EN
    // Timeout: emission exactly TIMEOUT edges after the accept edge.
    send(8'h5A, 1'b0, 1'b0);
    for (int i = 1; i < int'(TIMEOUT); i++) begin
      tick();
      check("timeout_wait_be", {14'b0, byteena}, 16'h0000);
    end
    tick();
    check("timeout_d", d, 16'h005A);
    check("timeout_be", {14'b0, byteena}, 16'h0001);
    // A byte is accepted on the very next cycle after a timeout flush.
    send(8'h99, 1'b0, 1'b1);
    check("after_timeout_d", d, 16'h0099);
    check("after_timeout_be", {14'b0, byteena}, 16'h0001);

    // Accept on the expiry cycle wins over the timeout.
    send(8'h3C, 1'b0, 1'b0);
    repeat (int'(TIMEOUT) - 1) tick();
    check("expiry_wait_be", {14'b0, byteena}, 16'h0000);
    send(8'hC3, 1'b1, 1'b0);
    check("expiry_accept_d", d, 16'hC33C);
    check("expiry_accept_be", {14'b0, byteena}, 16'h0003);
    tick();
    check("expiry_idle_be", {14'b0, byteena}, 16'h0000);
`else
    // Without the timeout a partial word waits indefinitely.
    send(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      tick();
      check("no_timeout_be", {14'b0, byteena}, 16'h0000);
    end
    send(8'hA5, 1'b1, 1'b0);
    check("late_complete_d", d, 16'hA55A);
    check("late_complete_be", {14'b0, byteena}, 16'h0003);
    tick();
    check("late_idle_be", {14'b0, byteena}, 16'h0000);
`endif

    // Random stream against the model, starting from a clean reset.
    pulse_reset();
    m_reset();
    tick();
    check("rnd_start_q", q, 16'h0000);
    for (int n = 0; n < 400; n++) begin
      gap = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 2);
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int g = 0; g < gap; g++) step(acc);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_lane  = 1'($urandom);
      in_last  = ($urandom_range(0, 3) == 0);
      got = 1'b0;
      for (int t = 0; t < 4 && !got; t++) begin
        step(acc);
        got = acc;
      end
      if (!got) begin
        n_checks++;
        n_errors++;
        $error("FAIL rnd_accept_bound: observed no accept expected accept within 4 cycles");
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int g = 0; g < 12; g++) step(acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
